// File: rtl/mii_rx_nibble_packer.sv
// ---------------------------------------------------------------------------
// mii_rx_nibble_packer
//
// Receive-side MII nibble-to-byte packer. Runs entirely on MII_RX_CLK rising
// edges, directly behind the PHY receive pins. Optionally hunts and strips
// preamble/SFD, assembles data bytes low nibble first, counts frame length
// (saturating at MAX_FRAME_BYTES+1) and reports per-frame status on a
// one-cycle FRAME_DONE pulse.
//
// Optional feature macro: MII_RX_CRC_CHECK_EN
//   defined   : CRC-32 (IEEE 802.3, reflected, init all-ones) runs over every
//               emitted byte, FCS included; FRAME_CRC_OK reports residue
//               match on a good frame.
//   undefined : no CRC logic, FRAME_CRC_OK tied low.
//
// Ports
//   MII_RX_CLK     in   receive clock (25 MHz / 2.5 MHz)
//   MII_RX_RESETN  in   asynchronous active-low reset
//   MII_RXD[3:0]   in   receive nibble
//   MII_RX_DV      in   receive data valid
//   MII_RX_ER      in   receive error
//   BYTE_DATA[7:0] out  assembled byte {high, low}; holds between strobes
//   BYTE_VALID     out  one-cycle byte strobe
//   BYTE_SOF       out  with BYTE_VALID on the first data byte of a frame
//   BYTE_ERR       out  with BYTE_VALID if RX_ER was seen on either nibble
//   FRAME_DONE     out  one-cycle end-of-frame pulse
//   FRAME_LEN      out  data bytes received (saturating), during FRAME_DONE
//   FRAME_BAD      out  RX_ER / odd nibbles / oversize / bad preamble
//   FRAME_CRC_OK   out  FCS residue matched and frame not bad
// ---------------------------------------------------------------------------
module mii_rx_nibble_packer #(
  parameter bit STRIP_PREAMBLE  = 1'b1,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int LEN_W           = 11
) (
  input  logic             MII_RX_CLK,
  input  logic             MII_RX_RESETN,
  input  logic [3:0]       MII_RXD,
  input  logic             MII_RX_DV,
  input  logic             MII_RX_ER,
  output logic [7:0]       BYTE_DATA,
  output logic             BYTE_VALID,
  output logic             BYTE_SOF,
  output logic             BYTE_ERR,
  output logic             FRAME_DONE,
  output logic [LEN_W-1:0] FRAME_LEN,
  output logic             FRAME_BAD,
  output logic             FRAME_CRC_OK
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_FRAME_BYTES);
  localparam logic [LEN_W-1:0] SAT_CNT = LEN_W'(MAX_FRAME_BYTES + 1);
  localparam logic [3:0]       NIB_PRE = 4'h5;
  localparam logic [3:0]       NIB_SFD = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOW,
    ST_HIGH,
    ST_DISCARD
  } state_e;

  state_e           state_q, state_d;

  // datapath / frame tracking
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic             lo_er_q, lo_er_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;      // sticky RX_ER seen with DV
  logic             ovf_q, ovf_d;      // byte count went past MAX
  // armed: DV has been seen low since reset. A burst that starts while not
  // armed was already running at reset release and must be skipped silently.
  logic             armed_q, armed_d;
  logic             silent_q, silent_d;

  // registered outputs
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_sof_q, byte_sof_d;
  logic             byte_err_q, byte_err_d;
  logic             frame_done_q, frame_done_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_bad_q, frame_bad_d;

  logic             dv_er;
  logic             emit;
  logic [7:0]       byte_nxt;
  logic             sof_nxt;

  assign dv_er    = MII_RX_DV & MII_RX_ER;
  assign byte_nxt = {MII_RXD, lo_nib_q};
  assign sof_nxt  = (cnt_q == '0);
  // a byte goes out only while the frame is still within MAX_FRAME_BYTES
  assign emit     = (state_q == ST_HIGH) && MII_RX_DV && (cnt_q < MAX_CNT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge MII_RX_CLK or negedge MII_RX_RESETN) begin
    if (!MII_RX_RESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MII_RX_DV) begin
          if (!armed_q)            state_d = ST_DISCARD;
          else if (STRIP_PREAMBLE) state_d = ST_HUNT;
          else                     state_d = ST_HIGH;
        end
      end
      ST_HUNT: begin
        if (!MII_RX_DV)              state_d = ST_IDLE;
        else if (MII_RXD == NIB_PRE) state_d = ST_HUNT;
        else if (MII_RXD == NIB_SFD) state_d = ST_LOW;
        else                         state_d = ST_DISCARD;
      end
      ST_LOW:     state_d = MII_RX_DV ? ST_HIGH : ST_IDLE;
      ST_HIGH:    state_d = MII_RX_DV ? ST_LOW  : ST_IDLE;
      ST_DISCARD: if (!MII_RX_DV) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    lo_nib_d     = lo_nib_q;
    lo_er_d      = lo_er_q;
    cnt_d        = cnt_q;
    err_d        = err_q | dv_er;
    ovf_d        = ovf_q;
    armed_d      = armed_q | ~MII_RX_DV;
    silent_d     = silent_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    byte_sof_d   = 1'b0;
    byte_err_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = '0;
    frame_bad_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MII_RX_DV) begin
          // new burst: clear per-frame tracking; the nibble is only data
          // when preamble stripping is off
          cnt_d    = '0;
          ovf_d    = 1'b0;
          err_d    = MII_RX_ER;
          silent_d = ~armed_q;
          lo_nib_d = MII_RXD;
          lo_er_d  = MII_RX_ER;
        end
      end
      ST_HUNT: begin
        if (!MII_RX_DV) begin
          // preamble-only burst
          frame_done_d = 1'b1;
          frame_bad_d  = 1'b1;
        end
      end
      ST_LOW: begin
        if (MII_RX_DV) begin
          lo_nib_d = MII_RXD;
          lo_er_d  = MII_RX_ER;
        end else begin
          frame_done_d = 1'b1;
          frame_len_d  = cnt_q;
          frame_bad_d  = err_q | ovf_q;
        end
      end
      ST_HIGH: begin
        if (MII_RX_DV) begin
          if (emit) begin
            byte_valid_d = 1'b1;
            byte_data_d  = byte_nxt;
            byte_sof_d   = sof_nxt;
            byte_err_d   = lo_er_q | MII_RX_ER;
            cnt_d        = cnt_q + 1'b1;
          end else begin
            cnt_d = SAT_CNT;
            ovf_d = 1'b1;
          end
        end else begin
          // odd nibble count: the latched low nibble is dropped
          frame_done_d = 1'b1;
          frame_len_d  = cnt_q;
          frame_bad_d  = 1'b1;
        end
      end
      ST_DISCARD: begin
        if (!MII_RX_DV) begin
          frame_done_d = ~silent_q;
          frame_bad_d  = ~silent_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MII_RX_CLK or negedge MII_RX_RESETN) begin
    if (!MII_RX_RESETN) begin
      lo_nib_q     <= '0;
      lo_er_q      <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      armed_q      <= 1'b0;
      silent_q     <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_sof_q   <= 1'b0;
      byte_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_bad_q  <= 1'b0;
    end else begin
      lo_nib_q     <= lo_nib_d;
      lo_er_q      <= lo_er_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      armed_q      <= armed_d;
      silent_q     <= silent_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_sof_q   <= byte_sof_d;
      byte_err_q   <= byte_err_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_bad_q  <= frame_bad_d;
    end
  end

  assign BYTE_DATA  = byte_data_q;
  assign BYTE_VALID = byte_valid_q;
  assign BYTE_SOF   = byte_sof_q;
  assign BYTE_ERR   = byte_err_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_LEN  = frame_len_q;
  assign FRAME_BAD  = frame_bad_q;

`ifdef MII_RX_CRC_CHECK_EN
  // -------------------------------------------------------------------------
  // CRC-32 over emitted bytes. The register restarts from all-ones on the
  // SOF byte; after data+FCS a good frame leaves the fixed residue.
  // -------------------------------------------------------------------------
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  logic [31:0] crc_q, crc_d;
  logic        crc_ok_q, crc_ok_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ d[i]}});
    end
    return c;
  endfunction

  always_comb begin
    crc_d    = crc_q;
    crc_ok_d = 1'b0;
    if (emit) crc_d = crc32_byte(sof_nxt ? 32'hFFFF_FFFF : crc_q, byte_nxt);
    // cnt_q != 0 keeps a stale register from an earlier frame out of play
    if (frame_done_d && !frame_bad_d && (cnt_q != '0))
      crc_ok_d = (crc_q == CRC_RESIDUE);
  end

  always_ff @(posedge MII_RX_CLK or negedge MII_RX_RESETN) begin
    if (!MII_RX_RESETN) begin
      crc_q    <= 32'hFFFF_FFFF;
      crc_ok_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  assign FRAME_CRC_OK = crc_ok_q;
`else
  assign FRAME_CRC_OK = 1'b0;
`endif

endmodule

// File: tb/tb_mii_rx_nibble_packer.sv
module tb_mii_rx_nibble_packer;
  localparam int MAXB = 1522;
  localparam int LW   = 11;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    rxd   = 4'h0;
  logic          dv    = 1'b0;
  logic          er    = 1'b0;
  logic [7:0]    byte_data;
  logic          byte_valid, byte_sof, byte_err, frame_done;
  logic [LW-1:0] frame_len;
  logic          frame_bad, frame_crc_ok;

  always #5 clk = ~clk;

  mii_rx_nibble_packer #(
    .STRIP_PREAMBLE (1'b1),
    .MAX_FRAME_BYTES(MAXB),
    .LEN_W          (LW)
  ) dut (
    .MII_RX_CLK   (clk),
    .MII_RX_RESETN(rst_n),
    .MII_RXD      (rxd),
    .MII_RX_DV    (dv),
    .MII_RX_ER    (er),
    .BYTE_DATA    (byte_data),
    .BYTE_VALID   (byte_valid),
    .BYTE_SOF     (byte_sof),
    .BYTE_ERR     (byte_err),
    .FRAME_DONE   (frame_done),
    .FRAME_LEN    (frame_len),
    .FRAME_BAD    (frame_bad),
    .FRAME_CRC_OK (frame_crc_ok)
  );

  typedef struct { logic [7:0] d; logic sof; logic err; int cyc; } byte_t;
  typedef struct { logic [LW-1:0] len; logic bad; logic crc; } frm_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  byte_t cap_b[$], exp_b[$];
  frm_t  cap_f[$], exp_f[$];
  logic [3:0] f_nib[$];
  logic       f_er[$];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: outputs sampled on the falling edge
  always @(negedge clk) begin
    byte_t b;
    frm_t  f;
    if (byte_valid === 1'b1) begin
      b.d = byte_data; b.sof = byte_sof; b.err = byte_err; b.cyc = cyc;
      cap_b.push_back(b);
    end
    if (frame_done === 1'b1) begin
      f.len = frame_len; f.bad = frame_bad; f.crc = frame_crc_ok;
      cap_f.push_back(f);
    end
  end

  function automatic logic rnd_er();
    return ($urandom_range(0, 29) == 0);
  endfunction

  task automatic clr();
    cap_b.delete(); cap_f.delete(); exp_b.delete(); exp_f.delete();
    f_nib.delete(); f_er.delete();
  endtask

  task automatic add(input logic [3:0] n, input logic e);
    f_nib.push_back(n); f_er.push_back(e);
  endtask

  task automatic add_pre(input int k);
    for (int i = 0; i < k; i++) add(4'h5, 1'b0);
    add(4'hD, 1'b0);
  endtask

  task automatic add_byte(input logic [7:0] b);
    add(b[3:0], 1'b0); add(b[7:4], 1'b0);
  endtask

  // DV low; RX_ER toggled at random since it must be ignored without DV
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk); dv = 1'b0; rxd = 4'($urandom); er = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic send(input int gap);
    foreach (f_nib[i]) begin
      @(negedge clk); dv = 1'b1; rxd = f_nib[i]; er = f_er[i];
    end
    idle(gap);
  endtask

  // reference: frame outcome derived from the nibble burst as a whole
  task automatic model_frame();
    int sfd, n, nd, nb;
    logic anyer;
    byte_t b;
    frm_t f;
    n = f_nib.size(); sfd = -1; anyer = 1'b0;
    foreach (f_er[i]) if (f_er[i]) anyer = 1'b1;
    // the first nibble of a burst only opens the hunt
    for (int i = 1; i < n; i++) begin
      if (f_nib[i] != 4'h5) begin
        if (f_nib[i] == 4'hD) sfd = i;
        break;
      end
    end
    f.crc = 1'b0;
    if (sfd < 0) begin
      f.len = '0; f.bad = 1'b1;
    end else begin
      nd = n - sfd - 1;
      nb = nd / 2;
      for (int j = 0; j < nb && j < MAXB; j++) begin
        b.d   = {f_nib[sfd + 2 + 2*j], f_nib[sfd + 1 + 2*j]};
        b.sof = (j == 0);
        b.err = f_er[sfd + 1 + 2*j] | f_er[sfd + 2 + 2*j];
        b.cyc = 0;
        exp_b.push_back(b);
      end
      f.len = LW'((nb > MAXB) ? MAXB + 1 : nb);
      f.bad = anyer | (nd % 2 == 1) | (nb > MAXB);
    end
    exp_f.push_back(f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); dv = 1'($urandom); er = 1'($urandom); rxd = 4'($urandom);
    end
    #1;
    n_cmp++; if ({byte_valid, byte_sof, byte_err, frame_done, frame_bad, frame_crc_ok} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b exp 000000", {byte_valid, byte_sof, byte_err, frame_done, frame_bad, frame_crc_ok}); end
    n_cmp++; if (byte_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h exp 00", byte_data); end
    n_cmp++; if (frame_len !== '0) begin n_bad++; $display("FAIL reset_len got %0d exp 0", frame_len); end
    @(negedge clk); dv = 1'b0; er = 1'b0; rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_basic();
    clr(); add_pre(15);
    add(4'h1, 1'b0); add(4'h2, 1'b0); add(4'h3, 1'b0); add(4'h4, 1'b0);
    send(4);
    n_cmp++; if (cap_b.size() !== 2) begin n_bad++; $display("FAIL basic_nbytes got %0d exp 2", cap_b.size()); end
    else begin
      n_cmp++; if ({cap_b[0].d, cap_b[0].sof, cap_b[0].err} !== {8'h21, 1'b1, 1'b0}) begin n_bad++; $display("FAIL basic_b0 got %h/%b/%b exp 21/1/0", cap_b[0].d, cap_b[0].sof, cap_b[0].err); end
      n_cmp++; if ({cap_b[1].d, cap_b[1].sof, cap_b[1].err} !== {8'h43, 1'b0, 1'b0}) begin n_bad++; $display("FAIL basic_b1 got %h/%b/%b exp 43/0/0", cap_b[1].d, cap_b[1].sof, cap_b[1].err); end
      n_cmp++; if (cap_b[1].cyc - cap_b[0].cyc !== 2) begin n_bad++; $display("FAIL basic_spacing got %0d exp 2", cap_b[1].cyc - cap_b[0].cyc); end
    end
    n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL basic_nframes got %0d exp 1", cap_f.size()); end
    else begin
      n_cmp++; if ({cap_f[0].len, cap_f[0].bad, cap_f[0].crc} !== {LW'(2), 1'b0, 1'b0}) begin n_bad++; $display("FAIL basic_status got len %0d bad %b crc %b exp 2/0/0", cap_f[0].len, cap_f[0].bad, cap_f[0].crc); end
    end
    n_cmp++; if (byte_data !== 8'h43) begin n_bad++; $display("FAIL basic_hold got %h exp 43", byte_data); end
  endtask

  task automatic test_odd();
    clr(); add_pre(15);
    for (int i = 1; i <= 5; i++) add(4'(i), 1'b0);
    send(4);
    n_cmp++; if (cap_b.size() !== 2) begin n_bad++; $display("FAIL odd_nbytes got %0d exp 2", cap_b.size()); end
    else begin
      n_cmp++; if ({cap_b[0].d, cap_b[1].d} !== 16'h2143) begin n_bad++; $display("FAIL odd_bytes got %h %h exp 21 43", cap_b[0].d, cap_b[1].d); end
    end
    n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL odd_nframes got %0d exp 1", cap_f.size()); end
    else begin
      n_cmp++; if ({cap_f[0].len, cap_f[0].bad} !== {LW'(2), 1'b1}) begin n_bad++; $display("FAIL odd_status got len %0d bad %b exp 2/1", cap_f[0].len, cap_f[0].bad); end
    end
  endtask

  task automatic test_rx_er();
    clr(); add_pre(15);
    add(4'h1, 1'b0); add(4'h2, 1'b0); add(4'h3, 1'b1); add(4'h4, 1'b0);
    send(4);
    n_cmp++; if (cap_b.size() !== 2) begin n_bad++; $display("FAIL rxer_nbytes got %0d exp 2", cap_b.size()); end
    else begin
      n_cmp++; if ({cap_b[0].err, cap_b[1].err} !== 2'b01) begin n_bad++; $display("FAIL rxer_byte_err got %b%b exp 01", cap_b[0].err, cap_b[1].err); end
    end
    n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL rxer_nframes got %0d exp 1", cap_f.size()); end
    else begin
      n_cmp++; if ({cap_f[0].len, cap_f[0].bad} !== {LW'(2), 1'b1}) begin n_bad++; $display("FAIL rxer_status got len %0d bad %b exp 2/1", cap_f[0].len, cap_f[0].bad); end
    end
  endtask

  task automatic test_bad_preamble();
    for (int k = 0; k < 2; k++) begin
      clr();
      if (k == 0) begin
        add(4'h5, 1'b0); add(4'h5, 1'b0); add(4'h7, 1'b0);
        for (int i = 1; i <= 4; i++) add(4'(i), 1'b0);
      end else begin
        for (int i = 0; i < 8; i++) add(4'h5, 1'b0);   // preamble only
      end
      send(4);
      n_cmp++; if (cap_b.size() !== 0) begin n_bad++; $display("FAIL badpre%0d_nbytes got %0d exp 0", k, cap_b.size()); end
      n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL badpre%0d_nframes got %0d exp 1", k, cap_f.size()); end
      else begin
        n_cmp++; if ({cap_f[0].len, cap_f[0].bad} !== {LW'(0), 1'b1}) begin n_bad++; $display("FAIL badpre%0d_status got len %0d bad %b exp 0/1", k, cap_f[0].len, cap_f[0].bad); end
      end
    end
  endtask

  task automatic test_back_to_back();
    clr(); add_pre(2);
    add(4'h1, 1'b0); add(4'h2, 1'b0); add(4'h3, 1'b0); add(4'h4, 1'b0);
    send(1);
    f_nib.delete(); f_er.delete(); add_pre(2);
    add(4'h6, 1'b0); add(4'h7, 1'b0); add(4'h8, 1'b0); add(4'h9, 1'b0);
    send(4);
    n_cmp++; if (cap_b.size() !== 4) begin n_bad++; $display("FAIL b2b_nbytes got %0d exp 4", cap_b.size()); end
    else begin
      n_cmp++; if ({cap_b[0].d, cap_b[1].d, cap_b[2].d, cap_b[3].d} !== 32'h21437698) begin n_bad++; $display("FAIL b2b_bytes got %h %h %h %h exp 21 43 76 98", cap_b[0].d, cap_b[1].d, cap_b[2].d, cap_b[3].d); end
      n_cmp++; if ({cap_b[0].sof, cap_b[1].sof, cap_b[2].sof, cap_b[3].sof} !== 4'b1010) begin n_bad++; $display("FAIL b2b_sof got %b%b%b%b exp 1010", cap_b[0].sof, cap_b[1].sof, cap_b[2].sof, cap_b[3].sof); end
    end
    n_cmp++; if (cap_f.size() !== 2) begin n_bad++; $display("FAIL b2b_nframes got %0d exp 2", cap_f.size()); end
    else begin
      n_cmp++; if ({cap_f[0].len, cap_f[0].bad, cap_f[1].len, cap_f[1].bad} !== {LW'(2), 1'b0, LW'(2), 1'b0}) begin n_bad++; $display("FAIL b2b_status got %0d/%b %0d/%b exp 2/0 2/0", cap_f[0].len, cap_f[0].bad, cap_f[1].len, cap_f[1].bad); end
    end
  endtask

  task automatic test_oversize();
    logic [7:0] data[$];
    for (int f = 0; f < 2; f++) begin
      clr(); data.delete(); add_pre(3);
      for (int i = 0; i < MAXB + 2*f; i++) begin
        data.push_back(8'($urandom)); add_byte(data[i]);
      end
      send(4);
      n_cmp++; if (cap_b.size() !== MAXB) begin n_bad++; $display("FAIL over%0d_nbytes got %0d exp %0d", f, cap_b.size(), MAXB); end
      else begin
        n_cmp++; if (cap_b[MAXB-1].d !== data[MAXB-1]) begin n_bad++; $display("FAIL over%0d_last got %h exp %h", f, cap_b[MAXB-1].d, data[MAXB-1]); end
      end
      n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL over%0d_nframes got %0d exp 1", f, cap_f.size()); end
      else begin
        n_cmp++; if ({cap_f[0].len, cap_f[0].bad} !== {LW'(MAXB + f), (f == 1)}) begin n_bad++; $display("FAIL over%0d_status got len %0d bad %b exp %0d/%0d", f, cap_f[0].len, cap_f[0].bad, MAXB + f, f); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clr(); add_pre(7);
    for (int i = 0; i < 4; i++) add_byte(8'($urandom));
    // nibble 9 is the high half of data byte 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); dv = 1'b1; rxd = f_nib[i]; er = 1'b0;
    end
    @(posedge clk); #2;
    n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid got %b exp 1", byte_valid); end
    rst_n = 1'b0; #1;
    n_cmp++; if ({byte_valid, byte_sof, byte_data, frame_done} !== 11'b0) begin n_bad++; $display("FAIL midrst_outs got %b/%b/%h/%b exp all 0", byte_valid, byte_sof, byte_data, frame_done); end
    idle(3);
    @(negedge clk); rst_n = 1'b1; dv = 1'b0;
    idle(6);
    n_cmp++; if (cap_f.size() !== 0) begin n_bad++; $display("FAIL midrst_done got %0d exp 0", cap_f.size()); end
  endtask

  task automatic test_dv_at_release();
    clr(); rst_n = 1'b0;
    @(negedge clk); dv = 1'b1; rxd = 4'h5; er = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); rxd = 4'h5; end
    @(negedge clk); rxd = 4'hD;
    for (int i = 0; i < 8; i++) begin @(negedge clk); rxd = 4'($urandom); end
    idle(5);
    n_cmp++; if ({cap_b.size(), cap_f.size()} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL relse_skip got %0d bytes %0d frames exp 0 0", cap_b.size(), cap_f.size()); end
    clr(); add_pre(3);
    add(4'h1, 1'b0); add(4'h2, 1'b0); add(4'h3, 1'b0); add(4'h4, 1'b0);
    send(4);
    n_cmp++; if (cap_b.size() !== 2) begin n_bad++; $display("FAIL relse_next_nbytes got %0d exp 2", cap_b.size()); end
    n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL relse_next_nframes got %0d exp 1", cap_f.size()); end
    else begin
      n_cmp++; if ({cap_f[0].len, cap_f[0].bad} !== {LW'(2), 1'b0}) begin n_bad++; $display("FAIL relse_next_status got %0d/%b exp 2/0", cap_f[0].len, cap_f[0].bad); end
    end
  endtask

  task automatic test_random();
    int npre, nd;
    clr();
    for (int fr = 0; fr < 40; fr++) begin
      f_nib.delete(); f_er.delete();
      npre = $urandom_range(0, 14);
      add(4'h5, rnd_er());
      for (int i = 0; i < npre; i++) add(4'h5, rnd_er());
      if (npre > 0 && $urandom_range(0, 7) == 0) f_nib[$urandom_range(1, npre)] = 4'($urandom);
      if ($urandom_range(0, 9) != 0) begin
        add(4'hD, rnd_er());
        nd = $urandom_range(0, 24);
        for (int i = 0; i < nd; i++) add(4'($urandom), rnd_er());
      end
      model_frame();
      send($urandom_range(1, 4));
    end
    idle(4);
    n_cmp++; if (cap_b.size() !== exp_b.size()) begin n_bad++; $display("FAIL rand_nbytes got %0d exp %0d", cap_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) begin
      n_cmp++; if ({cap_b[i].d, cap_b[i].sof, cap_b[i].err} !== {exp_b[i].d, exp_b[i].sof, exp_b[i].err}) begin n_bad++; $display("FAIL rand_byte[%0d] got %h/%b/%b exp %h/%b/%b", i, cap_b[i].d, cap_b[i].sof, cap_b[i].err, exp_b[i].d, exp_b[i].sof, exp_b[i].err); end
    end
    n_cmp++; if (cap_f.size() !== exp_f.size()) begin n_bad++; $display("FAIL rand_nframes got %0d exp %0d", cap_f.size(), exp_f.size()); end
    for (int i = 0; i < exp_f.size() && i < cap_f.size(); i++) begin
      n_cmp++; if ({cap_f[i].len, cap_f[i].bad, cap_f[i].crc} !== {exp_f[i].len, exp_f[i].bad, exp_f[i].crc}) begin n_bad++; $display("FAIL rand_frame[%0d] got %0d/%b/%b exp %0d/%b/%b", i, cap_f[i].len, cap_f[i].bad, cap_f[i].crc, exp_f[i].len, exp_f[i].bad, exp_f[i].crc); end
    end
  endtask

`ifdef MII_RX_CRC_CHECK_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) c = c[0] ^ d[i] ? (c >> 1) ^ 32'hEDB88320 : (c >> 1);
    return c;
  endfunction

  task automatic test_crc();
    logic [7:0]  data[64];
    logic [31:0] c;
    for (int pass = 0; pass < 2; pass++) begin
      clr(); c = 32'hFFFF_FFFF;
      for (int i = 0; i < 60; i++) begin data[i] = 8'($urandom); c = crc_upd(c, data[i]); end
      c = ~c;
      data[60] = c[7:0]; data[61] = c[15:8]; data[62] = c[23:16]; data[63] = c[31:24];
      if (pass == 1) data[10] = data[10] ^ 8'h04;
      add_pre(7);
      for (int i = 0; i < 64; i++) add_byte(data[i]);
      send(4);
      n_cmp++; if (cap_f.size() !== 1) begin n_bad++; $display("FAIL crc%0d_nframes got %0d exp 1", pass, cap_f.size()); end
      else begin
        n_cmp++; if ({cap_f[0].len, cap_f[0].bad, cap_f[0].crc} !== {LW'(64), 1'b0, (pass == 0)}) begin n_bad++; $display("FAIL crc%0d_status got %0d/%b/%b exp 64/0/%0d", pass, cap_f[0].len, cap_f[0].bad, cap_f[0].crc, pass == 0); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_rx_er();
    test_bad_preamble();
    test_back_to_back();
    test_reset_midframe();
    test_dv_at_release();
    test_oversize();
    test_random();
`ifdef MII_RX_CRC_CHECK_EN
    test_crc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
